// File: rtl/lane_sensor_pkg.sv
// Shared types and light decoding for the lane traffic sensor.
// YELLOW_DEPART_EN: when defined, yellow also permits departures.
package lane_sensor_pkg;

  typedef enum logic [1:0] {
    L_GREEN  = 2'b00,
    L_YELLOW = 2'b01,
    L_RED    = 2'b10
  } light_t;

  typedef enum logic {
    IDLE = 1'b0,
    PACE = 1'b1
  } dep_state_t;

  // 2'b11 is not a legal code and falls through as non-permitting (red)
  function automatic logic is_permit(input logic [1:0] l);
`ifdef YELLOW_DEPART_EN
    return (l == L_GREEN) || (l == L_YELLOW);
`else
    return (l == L_GREEN);
`endif
  endfunction

endpackage

// File: rtl/lane_traffic_sensor_arrival_debouncer.sv
// Loop detector front end: 2-flop synchronizer, stability counter, and a
// one-cycle arrive pulse on each rising edge of the debounced level.
module arrival_debouncer #(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic car_raw,
  output logic arrive
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC);

  logic [1:0]    sync_pipe;
  logic [DW-1:0] stab_cnt;
  logic          deb, deb_q;

  // Counter saturates at DEB_MAX so deb stays high while the loop stays occupied
  assign deb    = (stab_cnt == DEB_MAX);
  assign arrive = deb & ~deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      stab_cnt  <= '0;
      deb_q     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], car_raw};
      if (!sync_pipe[1])
        stab_cnt <= '0;
      else if (!deb)
        stab_cnt <= stab_cnt + 1'b1;
      deb_q <= deb;
    end
  end

endmodule

// File: rtl/lane_traffic_sensor.sv
// Sensor end of one approach lane: debounced arrivals, saturating queue,
// paced departures while the light permits. Option: YELLOW_DEPART_EN.
module lane_traffic_sensor
  import lane_sensor_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int DEB_CYC    = 3,
  parameter int DEPART_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car_raw,
  input  logic [1:0]       Lself,
  output logic             Tself,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             depart,
  output logic             overflow
);

  localparam int PW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [PW-1:0]    PACE_RLD = PW'(DEPART_CYC - 1);
  localparam logic [CNT_W-1:0] Q_MAX    = '1;

  logic             arrive;
  logic             perm;
  logic [CNT_W-1:0] q_nxt;
  dep_state_t       state, state_nxt;
  logic [PW-1:0]    pace_cnt, pace_nxt;

  arrival_debouncer #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .car_raw(car_raw),
    .arrive (arrive)
  );

  assign perm  = is_permit(Lself);
  assign Tself = (queue_cnt != '0);

  // Arrival and departure in the same cycle cancel; a full queue drops the arrival
  always_comb begin
    q_nxt = queue_cnt;
    if (arrive && !depart) begin
      if (queue_cnt != Q_MAX)
        q_nxt = queue_cnt + 1'b1;
    end else if (depart && !arrive) begin
      q_nxt = queue_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      queue_cnt <= q_nxt;
      if (arrive && !depart && queue_cnt == Q_MAX)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pace_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pace_cnt <= pace_nxt;
    end
  end

  // Reload uses the post-update queue so an arrival on the last depart keeps pacing
  always_comb begin
    state_nxt = state;
    pace_nxt  = pace_cnt;
    case (state)
      IDLE: begin
        if (perm && queue_cnt != '0) begin
          state_nxt = PACE;
          pace_nxt  = PACE_RLD;
        end
      end
      PACE: begin
        if (!perm) begin
          state_nxt = IDLE;
        end else if (pace_cnt == '0) begin
          if (q_nxt != '0)
            pace_nxt = PACE_RLD;
          else
            state_nxt = IDLE;
        end else begin
          pace_nxt = pace_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    depart = (state == PACE) && perm && (pace_cnt == '0) && (queue_cnt != '0);
  end

endmodule

// File: tb/tb_lane_traffic_sensor.sv
// Self-checking bench for lane_traffic_sensor: directed scenarios plus random
// traffic, compared each cycle against a sample-history / queue model.
module tb_lane_traffic_sensor;

  localparam int CNT_W = 4;
  localparam int DEB   = 3;
  localparam int DEP   = 2;
  localparam int MAXQ  = 15;
  localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             car_raw;
  logic [1:0]       Lself;
  logic             Tself;
  logic [CNT_W-1:0] queue_cnt;
  logic             depart;
  logic             overflow;

  lane_traffic_sensor #(.CNT_W(CNT_W), .DEB_CYC(DEB), .DEPART_CYC(DEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .car_raw  (car_raw),
    .Lself    (Lself),
    .Tself    (Tself),
    .queue_cnt(queue_cnt),
    .depart   (depart),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int dep_at[$];

  // Model: raw-sample history (hist[0] newest), queue, sticky flag, pacing timer
  logic [DEB+2:0] hist = '0;
  int mq = 0;
  bit movf = 0;
  bit mact = 0;
  int mel = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cycle, got, exp);
    end
  endtask

  function automatic bit perm_of(input logic [1:0] l);
`ifdef YELLOW_DEPART_EN
    return (l == GREEN) || (l == YELLOW);
`else
    return (l == GREEN);
`endif
  endfunction

  function automatic bit m_dep();
    return mact && perm_of(Lself) && (mel >= DEP - 1) && (mq != 0);
  endfunction

  // An arrival lands at an edge when the raw samples taken 3..DEB+2 edges earlier
  // were all high and the one before them was low.
  task automatic model_step();
    bit arr, dep;
    int qn;
    if (!rst_n) begin
      mq = 0; movf = 0; mact = 0; mel = 0; hist = '0;
      return;
    end
    arr = (&hist[DEB+1:2]) && !hist[DEB+2];
    dep = m_dep();
    qn  = mq;
    if (arr && !dep) begin
      if (mq == MAXQ) movf = 1; else qn = mq + 1;
    end else if (dep && !arr) begin
      qn = mq - 1;
    end
    if (mact) begin
      if (!perm_of(Lself)) mact = 0;
      else if (dep) begin
        if (qn != 0) mel = 0; else mact = 0;
      end else mel++;
    end else if (perm_of(Lself) && mq != 0) begin
      mact = 1; mel = 0;
    end
    mq   = qn;
    hist = {hist[DEB+1:0], car_raw};
  endtask

  // One clock: compare on the falling edge, drive, let the model follow the rising edge
  task automatic cyc(input bit raw, input logic [1:0] l, input bit rst);
    bit was_run;
    @(negedge clk);
    chk("queue_cnt", queue_cnt, mq);
    chk("Tself", Tself, int'(mq != 0));
    chk("depart", depart, m_dep());
    chk("overflow", overflow, movf);
    if (depart) dep_at.push_back(cycle);
    was_run = rst_n;
    car_raw = raw; Lself = l; rst_n = !rst;
    if (rst && was_run) begin
      #1;
      chk("rst_async_q", queue_cnt, 0);
      chk("rst_async_T", Tself, 0);
      chk("rst_async_dep", depart, 0);
      chk("rst_async_ovf", overflow, 0);
    end
    @(posedge clk);
    model_step();
    cycle++;
    #1;
  endtask

  task automatic add_car();
    repeat (DEB + 3) cyc(1'b1, RED, 1'b0);
    repeat (2) cyc(1'b0, RED, 1'b0);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b0, RED, 1'b1);
    cyc(1'b0, RED, 1'b0);
  endtask

  initial begin
    bit raw;
    logic [1:0] lt;
    int rst_hold;
    rst_n = 1'b0; car_raw = 1'b0; Lself = RED;

    repeat (3) cyc(1'b0, RED, 1'b1);
    chk("reset_q", queue_cnt, 0);
    chk("reset_T", Tself, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_dep", depart, 0);
    repeat (2) cyc(1'b0, RED, 1'b0);

    // Short glitch is rejected; a held loop is counted at the fifth edge
    repeat (2) cyc(1'b1, RED, 1'b0);
    repeat (6) cyc(1'b0, RED, 1'b0);
    chk("glitch_q", queue_cnt, 0);
    repeat (5) cyc(1'b1, RED, 1'b0);
    chk("deb_edge4_q", queue_cnt, 0);
    cyc(1'b1, RED, 1'b0);
    chk("deb_edge5_q", queue_cnt, 1);
    repeat (3) cyc(1'b0, RED, 1'b0);

    // Reset in the middle of pacing
    repeat (2) add_car();
    chk("pre_rst_q", queue_cnt, 3);
    repeat (2) cyc(1'b0, GREEN, 1'b0);
    cyc(1'b0, GREEN, 1'b1);
    cyc(1'b0, GREEN, 1'b1);
    dep_at.delete();
    repeat (6) cyc(1'b0, GREEN, 1'b0);
    chk("post_rst_deps", dep_at.size(), 0);
    chk("post_rst_q", queue_cnt, 0);

    // Red holds the queue
    cyc(1'b0, RED, 1'b0);
    dep_at.delete();
    repeat (3) add_car();
    repeat (6) cyc(1'b0, RED, 1'b0);
    chk("red_q", queue_cnt, 3);
    chk("red_T", Tself, 1);
    chk("red_deps", dep_at.size(), 0);

    // Green drains three vehicles, two cycles apart
    dep_at.delete();
    repeat (8) cyc(1'b0, GREEN, 1'b0);
    chk("drain_deps", dep_at.size(), 3);
    if (dep_at.size() == 3) begin
      chk("drain_gap1", dep_at[1] - dep_at[0], 2);
      chk("drain_gap2", dep_at[2] - dep_at[1], 2);
    end
    chk("drain_q", queue_cnt, 0);
    chk("drain_T", Tself, 0);

    // Arrival landing on a departure edge leaves the count unchanged
    cyc(1'b0, RED, 1'b0);
    repeat (2) add_car();
    dep_at.delete();
    repeat (3) cyc(1'b1, RED, 1'b0);
    repeat (3) cyc(1'b1, GREEN, 1'b0);
    chk("simul_deps", dep_at.size(), 1);
    chk("simul_q", queue_cnt, 2);
    repeat (4) cyc(1'b0, RED, 1'b0);

    // Saturation and sticky overflow
    do_reset();
    repeat (15) add_car();
    chk("full_q", queue_cnt, 15);
    chk("full_ovf", overflow, 0);
    add_car();
    chk("ovf_q", queue_cnt, 15);
    chk("ovf_flag", overflow, 1);
    repeat (3) cyc(1'b0, RED, 1'b0);
    chk("ovf_sticky", overflow, 1);

    // Green turns yellow mid-pace
    do_reset();
    repeat (2) add_car();
    dep_at.delete();
    cyc(1'b0, GREEN, 1'b0);
    repeat (8) cyc(1'b0, YELLOW, 1'b0);
`ifdef YELLOW_DEPART_EN
    chk("yellow_q", queue_cnt, 0);
    chk("yellow_deps", dep_at.size(), 2);
`else
    chk("yellow_q", queue_cnt, 2);
    chk("yellow_deps", dep_at.size(), 0);
`endif

    // Random traffic, light changes and occasional resets
    raw = 1'b0; lt = RED; rst_hold = 0;
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) raw = ~raw;
      if ($urandom_range(0, 11) == 0) lt = 2'($urandom_range(0, 3));
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 499) == 0) rst_hold = 2;
      cyc(raw, lt, rst_hold > 0);
    end
    cyc(1'b0, RED, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
